// File: rtl/mult8_pkg.sv
// Shared types and constants for the 8-bit signed add-shift multiplier controller.
package mult8_pkg;

  localparam int unsigned MULT_WIDTH = 8;
  localparam int unsigned MULT_ITERS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADD,
    SHIFT,
    DONE
  } mult8_state_t;

  typedef logic [2:0] mult8_count_t;

endpackage

// File: rtl/mult8_fsm.sv
// Sequencer for the add-shift multiplier: state, iteration count and datapath strobes.
// MULT_SKIP_ADD_EN: bypass ADD cycles whose multiplier bit is 0.
module mult8_fsm
  import mult8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr_ld,
`ifdef MULT_SKIP_ADD_EN
  input  logic [1:0] b_lsb,
`endif
  output logic       ld_b,
  output logic       clr_a,
  output logic       ld_s,
  output logic       add_en,
  output logic       shift_en,
  output logic       fn,
  output logic       done
);

  mult8_state_t state, state_nxt;
  mult8_count_t count, count_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (!clr_ld && run) state_nxt = START;
      end
      START: begin
        count_nxt = '0;
        state_nxt = ADD;
`ifdef MULT_SKIP_ADD_EN
        if (!b_lsb[0]) state_nxt = SHIFT;
`endif
      end
      ADD: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        count_nxt = count + 1'b1;
        if (count == mult8_count_t'(MULT_ITERS - 1)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = ADD;
`ifdef MULT_SKIP_ADD_EN
          // b_lsb[1] becomes B[0] once this shift lands
          if (!b_lsb[1]) state_nxt = SHIFT;
`endif
        end
      end
      DONE: begin
        if (!clr_ld && !run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      fn    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      fn    <= (state_nxt == ADD) && (count_nxt == mult8_count_t'(MULT_ITERS - 1));
      done  <= (state_nxt == DONE);
    end
  end

  assign ld_b     = ((state == IDLE) || (state == DONE)) && clr_ld;
  assign ld_s     = (state == START);
  assign clr_a    = ld_b || ld_s;
  assign add_en   = (state == ADD);
  assign shift_en = (state == SHIFT);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Register file {X,A,B,S} and sequencing for the 8-bit signed add-shift multiplier.
// MULT_SKIP_ADD_EN: skip ADD cycles for zero multiplier bits (same result, shorter latency).
module mult8_seq_ctrl
  import mult8_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Din,
  input  logic [WIDTH-1:0] add_s,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_fn,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             done
);

  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             x_q;
  logic             ld_b, clr_a, ld_s, add_en, shift_en, fn;
  logic             o_msb, x_nxt;

  mult8_fsm u_fsm (
    .clk      (Clk),
    .rst      (Reset),
    .run      (Run),
    .clr_ld   (ClearA_LoadB),
`ifdef MULT_SKIP_ADD_EN
    .b_lsb    (b_q[1:0]),
`endif
    .ld_b     (ld_b),
    .clr_a    (clr_a),
    .ld_s     (ld_s),
    .add_en   (add_en),
    .shift_en (shift_en),
    .fn       (fn),
    .done     (done)
  );

  // Bit 8 of the sign-extended 9-bit sum; o_msb is the adder's effective operand sign
  assign o_msb = s_q[WIDTH-1] ^ fn;
  assign x_nxt = (a_q[WIDTH-1] & o_msb) | ((a_q[WIDTH-1] ^ o_msb) & add_s[WIDTH-1]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      x_q <= 1'b0;
    end else begin
      if (ld_b) b_q <= Din;
      if (ld_s) s_q <= Din;
      if (clr_a) begin
        a_q <= '0;
        x_q <= 1'b0;
      end
      if (add_en && b_q[0]) begin
        a_q <= add_s;
        x_q <= x_nxt;
      end
      if (shift_en) begin
        a_q <= {x_q, a_q[WIDTH-1:1]};
        b_q <= {a_q[0], b_q[WIDTH-1:1]};
      end
    end
  end

  assign add_a  = a_q;
  assign add_b  = s_q;
  assign add_fn = fn;
  assign Aval   = a_q;
  assign Bval   = b_q;
  assign Xval   = x_q;

endmodule

// File: doc/mult8_seq_ctrl.md
Name: mult8_seq_ctrl

Overview:
- Sequential add-shift controller and register file for the 8-bit signed multiplier.
- Holds the multiplicand S, the accumulator {X,A} and the multiplier/low-product register B.
- Drives the 8-bit add/sub adder through add_a/add_b/add_fn, takes its sum back on add_s, and sequences 8 add/shift iterations into a 16-bit product.
- Sits between the switch/button front end and the hex-display back end.

Parameters:
- WIDTH, 8, operand width. Fixed to 8 to match the adder; other values are not supported.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Run  input  1  level; starts one multiply, re-armed only after deassertion
- ClearA_LoadB  input  1  level; loads B from Din and clears X and A
- Din  input  8  switch operand (multiplier on load, multiplicand on start)
- add_s  input  8  sum returned by the adder
- add_a  output  8  adder operand A (= A register)
- add_b  output  8  adder operand B (= S register)
- add_fn  output  1  adder mode; 1 = subtract
- Aval  output  8  A register (upper product)
- Bval  output  8  B register (lower product)
- Xval  output  1  sign-extension bit X
- done  output  1  high while in DONE

Behaviour:
- Reset (async, any state): state=IDLE; A, B, S, X, count and done all 0. Because of this, add_a, add_b and add_fn are also 0 after reset.
- FSM states: IDLE, START, ADD, SHIFT, DONE. count is 3 bits.
- IDLE:
  - ClearA_LoadB=1 -> B<=Din, A<=0, X<=0; stay in IDLE. This has priority over Run in the same cycle.
  - Else Run=1 -> START.
- START (1 cycle): S<=Din, A<=0, X<=0, count<=0 -> ADD.
- ADD (1 cycle):
  - add_fn = (count==7), so the final iteration subtracts the multiplicand (two's-complement multiplier).
  - If B[0]=1: A<=add_s and X<=(A7&O7)|((A7^O7)&add_s[7]), where O7 = S[7]^add_fn. This is bit 8 of the sign-extended 9-bit result.
  - If B[0]=0: A and X hold.
  - Next state is SHIFT.
- SHIFT (1 cycle):
  - Arithmetic right shift of {X,A,B}: X holds, A<={X,A[7:1]}, B<={A[0],B[7:1]}.
  - count<=count+1.
  - If count==7 -> DONE, else -> ADD. count wraps to 0, which is harmless.
- DONE:
  - done=1; registers hold.
  - Run=0 -> IDLE. Run held high never restarts the multiply.
  - ClearA_LoadB=1 in DONE behaves as in IDLE and stays in DONE.
- Ignored inputs: ClearA_LoadB and Din are ignored in START, ADD and SHIFT. Din is sampled only at load and at START.
- add_a=A and add_b=S continuously. add_fn=1 only in ADD with count==7, else 0.
- Latency: Run sampled high at edge 0 -> START at cycle 1 -> ADD/SHIFT pairs in cycles 2..17 -> done=1 from cycle 18.
- Result: {Aval,Bval} is the signed 16-bit product; Xval equals Aval[7].
- Reset asserted mid-operation aborts immediately to the reset values.

Optional Feature:
- Macro: MULT_SKIP_ADD_EN.
- Defined: in SHIFT, if the next state would be ADD and the post-shift B[0] is 0, go straight to SHIFT again. The same applies from START when B[0]=0. Latency becomes 1 + 8 + popcount(B) cycles to DONE, and results are identical.
- Undefined: fixed 2-cycle iterations as above.

Decomposition:
- Package mult8_pkg:
  - state enum mult8_state_t {IDLE, START, ADD, SHIFT, DONE}
  - localparam MULT_WIDTH=8
  - localparam MULT_ITERS=8
  - count type logic [2:0]
- Sub-module mult8_fsm: state register, count and next-state logic. It outputs ld_b, clr_a, ld_s, add_en, shift_en, fn and done.
- The top level holds the datapath registers and the X computation. The adder is instantiated outside this block.

Test Plan:
- Load B=0x03, Run with Din=0x07 -> done at cycle 18; Aval=0x00, Bval=0x15, Xval=0.
- Load B=0xFD, Run with Din=0x05 -> Aval=0xFF, Bval=0xF1, Xval=1 (-15).
- Load B=0x80, Run with Din=0x80 -> Aval=0x40, Bval=0x00, Xval=0. This exercises the subtract path and the X formula.
- Load B=0xFF, Run with Din=0xFF, then hold Run for 10 cycles -> Aval=0x00, Bval=0x01. done stays high and there is no second multiply. Drop Run -> IDLE; raise Run again -> computes on the current B.
- Assert Reset asynchronously in the 5th SHIFT, with ClearA_LoadB and Run both high in the same IDLE cycle -> all outputs 0 immediately. After release, B loads and no START occurs that cycle.
- MULT_SKIP_ADD_EN defined, B=0x01, Din=0x09 -> done at cycle 11 and Bval=0x09. Same result with the macro undefined at cycle 18.
